// File: rtl/sort_resp_pkg.sv
// Shared definitions for the bubble-sort test responder.
//   state_t   : responder FSM states
//   LFSR_TAPS : Galois feedback mask for the 32-bit fill generator
//   lfsr_next : one Galois step (right shift, taps XORed in when bit 0 falls out)
package sort_resp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SORT,
        CHECK,
        DONE
    } state_t;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR used to generate the fill data.
//   clk     in  : clock
//   reset   in  : synchronous active-low; loads seed
//   seed    in  : start value (nonzero)
//   advance in  : step one position this cycle
//   value   out : current register contents
module lfsr32
    import sort_resp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] value
);

    always_ff @(posedge clk) begin
        if (!reset)
            value <= seed;
        else if (advance)
            value <= lfsr_next(value);
    end

endmodule

// File: rtl/bubblesort_test_responder.sv
// Responder side of the test method-call handshake. An accepted request fills
// an internal array from an LFSR, bubble-sorts it in place (one compare per
// cycle), verifies the ordering and returns the verdict on test_return.
//   clk              in  : clock
//   reset            in  : synchronous active-low
//   test_req         in  : method request, rising edge accepted while idle
//   test_busy        out : high while the method executes
//   test_return      out : 1 = array verified sorted, valid while not busy
//   finish_flag_out  out : field read value, set on completion
//   finish_flag_in   in  : field write data
//   finish_flag_we   in  : field write enable (beats the completion set)
//   fault_inject     in  : sampled at accept; suppresses all swaps
module bubblesort_test_responder
    import sort_resp_pkg::*;
#(
    parameter int          DEPTH = 8,
    parameter int          WIDTH = 32,
    parameter logic [31:0] SEED  = 32'h1
) (
    input  logic clk,
    input  logic reset,
    input  logic test_req,
    output logic test_busy,
    output logic test_return,
    output logic finish_flag_out,
    input  logic finish_flag_in,
    input  logic finish_flag_we,
    input  logic fault_inject
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t                   state, state_nxt;
    logic                     req_d;
    logic                     fault;
    logic [CW-1:0]            idx;      // fill index, reused as check index
    logic [CW-1:0]            j;
    logic [CW-1:0]            pass;
    logic                     swapped;
    logic                     ok;
    logic [DEPTH*WIDTH-1:0]   arr;
    logic [31:0]              lfsr_val;

    logic                     accept;
    logic [WIDTH-1:0]         a_j, a_j1, c_lo, c_hi;
    logic                     do_swap, swapped_eff, last_j, end_sort;
    logic                     fill_last, check_last;

    // Bounds-guarded element read: indices past the end only occur in states
    // where the value is ignored.
    function automatic logic [WIDTH-1:0] elem(input logic [DEPTH*WIDTH-1:0] v, input int k);
        if (k < DEPTH)
            return v[k*WIDTH +: WIDTH];
        return '0;
    endfunction

    lfsr32 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .seed    (SEED),
        .advance (state == FILL),
        .value   (lfsr_val)
    );

    always_comb begin
        state_nxt   = state;
        accept      = (state == IDLE) && test_req && !req_d;
        a_j         = elem(arr, int'(j));
        a_j1        = elem(arr, int'(j) + 1);
        c_lo        = elem(arr, int'(idx));
        c_hi        = elem(arr, int'(idx) + 1);
        do_swap     = (state == SORT) && (a_j > a_j1) && !fault;
        // The swap decided this cycle counts toward the end-of-pass test.
        swapped_eff = swapped | do_swap;
        last_j      = (j == CW'(DEPTH - 2) - pass);
        end_sort    = !swapped_eff || (pass == CW'(DEPTH - 2));
        fill_last   = (idx == CW'(DEPTH - 1));
        check_last  = (idx == CW'(DEPTH - 2));
        case (state)
            IDLE:    if (accept)              state_nxt = FILL;
            FILL:    if (fill_last)           state_nxt = SORT;
            SORT:    if (last_j && end_sort)  state_nxt = CHECK;
            CHECK:   if (check_last)          state_nxt = DONE;
            DONE:                             state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            test_busy       <= 1'b0;
            test_return     <= 1'b0;
            finish_flag_out <= 1'b0;
            req_d           <= 1'b0;
            fault           <= 1'b0;
            idx             <= '0;
            j               <= '0;
            pass            <= '0;
            swapped         <= 1'b0;
            ok              <= 1'b0;
        end else begin
            req_d <= test_req;
            case (state)
                IDLE: begin
                    if (accept) begin
                        test_busy   <= 1'b1;
                        test_return <= 1'b0;
                        fault       <= fault_inject;
                        idx         <= '0;
                    end
                end
                FILL: begin
                    arr[int'(idx)*WIDTH +: WIDTH] <= lfsr_val[WIDTH-1:0];
                    if (fill_last) begin
                        idx     <= '0;
                        j       <= '0;
                        pass    <= '0;
                        swapped <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                SORT: begin
                    if (do_swap) begin
                        arr[int'(j)*WIDTH +: WIDTH]       <= a_j1;
                        arr[(int'(j)+1)*WIDTH +: WIDTH]   <= a_j;
                    end
                    if (last_j) begin
                        j       <= '0;
                        swapped <= 1'b0;
                        if (end_sort) begin
                            idx <= '0;
                            ok  <= 1'b1;
                        end else begin
                            pass <= pass + 1'b1;
                        end
                    end else begin
                        j       <= j + 1'b1;
                        swapped <= swapped_eff;
                    end
                end
                CHECK: begin
                    ok  <= ok & (c_lo <= c_hi);
                    idx <= idx + 1'b1;
                end
                DONE: begin
                    test_return     <= ok;
                    test_busy       <= 1'b0;
                    finish_flag_out <= 1'b1;
                end
                default: ;
            endcase
            // Placed last so an external write overrides the completion set.
            if (finish_flag_we)
                finish_flag_out <= finish_flag_in;
        end
    end

endmodule

// File: tb/tb_bubblesort_test_responder.sv
module tb_bubblesort_test_responder;

    localparam int          DEPTH = 8;
    localparam int          WIDTH = 32;
    localparam logic [31:0] SEED  = 32'h1;

    logic clk = 1'b0;
    logic reset, test_req, finish_flag_in, finish_flag_we, fault_inject;
    logic test_busy, test_return, finish_flag_out;

    always #5 clk = ~clk;

    bubblesort_test_responder #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SEED(SEED)) dut (
        .clk             (clk),
        .reset           (reset),
        .test_req        (test_req),
        .test_busy       (test_busy),
        .test_return     (test_return),
        .finish_flag_out (finish_flag_out),
        .finish_flag_in  (finish_flag_in),
        .finish_flag_we  (finish_flag_we),
        .fault_inject    (fault_inject)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mlfsr;
    logic        mreq_d, m_busy, m_ret, m_flag, m_ok;
    int          m_cnt;
    logic [31:0] m_fill [DEPTH];

    function automatic logic [31:0] lstep(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    endfunction

    always @(posedge clk) begin
        logic acc;
        int   lmax, cnt, npass, s;
        logic [31:0] q[$];
        if (!reset) begin
            mreq_d = 1'b0; mlfsr = SEED; m_busy = 1'b0; m_ret = 1'b0;
            m_flag = 1'b0; m_cnt = 0;
        end else begin
            acc    = !m_busy && test_req && !mreq_d;
            mreq_d = test_req;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0; m_ret = m_ok; m_flag = 1'b1;
                end
            end else if (acc) begin
                for (int i = 0; i < DEPTH; i++) begin
                    m_fill[i] = mlfsr;
                    mlfsr = lstep(mlfsr);
                end
                // Passes that swap = largest count of bigger predecessors of
                // any element; one more clean pass ends the sort, capped.
                lmax = 0;
                for (int i = 0; i < DEPTH; i++) begin
                    cnt = 0;
                    for (int k = 0; k < i; k++)
                        if (m_fill[k] > m_fill[i]) cnt++;
                    if (cnt > lmax) lmax = cnt;
                end
                q = {};
                for (int i = 0; i < DEPTH; i++) q.push_back(m_fill[i]);
                if (fault_inject) npass = 1;
                else begin
                    npass = (lmax + 1 < DEPTH - 1) ? lmax + 1 : DEPTH - 1;
                    q.sort();
                end
                m_ok = 1'b1;
                for (int i = 0; i < DEPTH - 1; i++)
                    if (q[i] > q[i+1]) m_ok = 1'b0;
                s = 0;
                for (int p = 0; p < npass; p++) s += DEPTH - 1 - p;
                m_cnt  = DEPTH + s + (DEPTH - 1) + 1;
                m_busy = 1'b1;
                m_ret  = 1'b0;
            end
            if (finish_flag_we) m_flag = finish_flag_in;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic chk_en = 1'b0;
    int   run = 0;
    int   last_len = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'b0, test_busy}, {31'b0, m_busy});
            check("return", {31'b0, test_return}, {31'b0, m_ret});
            check("finish_flag", {31'b0, finish_flag_out}, {31'b0, m_flag});
            if (test_busy) run++;
            else if (run > 0) begin
                last_len = run;
                run = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while (test_busy && c < 100) begin
            tick(1);
            c++;
        end
        if (test_busy) begin
            n_tests++; n_fail++;
            $display("FAIL %s: busy still high after %0d cycles", name, c);
        end
        tick(1);
    endtask

    initial begin
        reset = 1'b1; test_req = 1'b0; finish_flag_in = 1'b0;
        finish_flag_we = 1'b0; fault_inject = 1'b0;

        // 1: reset held low across edges 3..8
        tick(2);
        reset = 1'b0;
        tick(1);
        chk_en = 1'b1;
        tick(5);
        reset = 1'b1;
        tick(2);
        check("rst_busy", {31'b0, test_busy}, 32'd0);
        check("rst_return", {31'b0, test_return}, 32'd0);
        check("rst_flag", {31'b0, finish_flag_out}, 32'd0);

        // 2: first call from reset, request held high
        tick(88);
        test_req = 1'b1;
        tick(1);
        check("t2_busy_next", {31'b0, test_busy}, 32'd1);
        wait_idle("t2_timeout");
        check("t2_fill3", m_fill[3], 32'h6018_0001);
        check("t2_fill7", m_fill[7], 32'hB62D_8003);
        check("t2_busy_len", last_len, 32'd41);
        check("t2_return", {31'b0, test_return}, 32'd1);
        check("t2_flag", {31'b0, finish_flag_out}, 32'd1);
        tick(20);
        check("t2_no_rerun", {31'b0, test_busy}, 32'd0);

        // 3: same data again from reset, swaps suppressed
        test_req = 1'b0;
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        fault_inject = 1'b1;
        test_req = 1'b1;
        tick(1);
        fault_inject = 1'b0;
        wait_idle("t3_timeout");
        check("t3_return", {31'b0, test_return}, 32'd0);
        check("t3_busy_len", last_len, 32'd23);

        // 4: fresh call on continued LFSR, with an ignored pulse while busy
        test_req = 1'b0;
        tick(2);
        test_req = 1'b1;
        tick(5);
        test_req = 1'b0;
        tick(1);
        test_req = 1'b1;
        wait_idle("t4_timeout");
        for (int i = 0; i < DEPTH; i++) $display("[TB] call4 a[%0d]=%08h", i, m_fill[i]);
        check("t4_return", {31'b0, test_return}, 32'd1);
        check("t4_len_min", {31'b0, last_len >= 23}, 32'd1);
        check("t4_len_max", {31'b0, last_len <= 44}, 32'd1);
        tick(10);
        check("t4_ignored", {31'b0, test_busy}, 32'd0);

        // 5: external flag write coincident with completion wins
        test_req = 1'b0;
        tick(2);
        test_req = 1'b1;
        tick(1);
        begin
            int c = 0;
            while (!(m_busy && m_cnt == 1) && c < 100) begin
                tick(1);
                c++;
            end
        end
        finish_flag_we = 1'b1;
        finish_flag_in = 1'b0;
        tick(1);
        finish_flag_we = 1'b0;
        tick(1);
        check("t5_flag_cleared", {31'b0, finish_flag_out}, 32'd0);
        check("t5_return", {31'b0, test_return}, 32'd1);
        finish_flag_we = 1'b1;
        finish_flag_in = 1'b1;
        tick(1);
        finish_flag_we = 1'b0;
        tick(1);
        check("t5_flag_set", {31'b0, finish_flag_out}, 32'd1);

        // 6: reset during SORT aborts, then a new call completes
        test_req = 1'b0;
        tick(2);
        test_req = 1'b1;
        tick(12);
        reset = 1'b0;
        test_req = 1'b0;
        tick(1);
        reset = 1'b1;
        check("t6_busy", {31'b0, test_busy}, 32'd0);
        check("t6_return", {31'b0, test_return}, 32'd0);
        check("t6_flag", {31'b0, finish_flag_out}, 32'd0);
        tick(1);
        test_req = 1'b1;
        tick(1);
        check("t6_busy_again", {31'b0, test_busy}, 32'd1);
        wait_idle("t6_timeout");
        check("t6_return_ok", {31'b0, test_return}, 32'd1);
        check("t6_busy_len", last_len, 32'd41);

        tick(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
